piso_serializer: RTL and testbench

//  Parallel-in serial-out transmitter: accepts a WIDTH-bit word via valid/ready handshake and

---
 rtl/piso_serializer_if.sv | 34 +++
 rtl/piso_serializer.sv | 160 ++++++++++++++++
 tb/tb_piso_serializer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - handshake and serial-output bundle for piso_serializer
//
// Purpose: groups the word-load handshake and the serial output of the
// parallel-in serial-out transmitter so that producer and serializer connect
// through a single port.
// Signals:
//   data_in     WIDTH  parallel word, sampled on accept        (master -> slave)
//   load_valid  1      upstream has a word on data_in          (master -> slave)
//   load_ready  1      serializer can accept a word this cycle (slave -> master)
//   dout        1      serial bit                              (slave -> master)
//   dout_valid  1      dout carries a frame bit                (slave -> master)
//   busy        1      frame in progress                       (slave -> master)
//   done        1      pulse with the final bit of a frame     (slave -> master)
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with gapless reload
//
// Purpose: accepts a WIDTH-bit word on a valid/ready handshake and emits it one
// bit per clock on dout, qualified by dout_valid. A word offered while the last
// frame bit is on dout is taken on that edge, so frames stream without gaps.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
// Ports:
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   ser_if  slave modport of piso_serializer_if (handshake + serial output)
// Parameters:
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: data[WIDTH-1] leaves first; 0: data[0] leaves first
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  piso_serializer_if.slave    ser_if
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] S_PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             load_ready;
  logic             accept;
  logic             do_load;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // sr_q holds only the bits still waiting to leave; the bit currently on
  // dout has already been moved into dout_q, and cnt_q is its frame index.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Ready in idle, or while the final frame bit is on dout so the next word
  // can be loaded on the same edge that retires it.
`ifdef PISO_PARITY_EN
  assign load_ready = rst_n & ((state_q == S_IDLE) | (state_q == S_PARITY));
`else
  assign load_ready = rst_n & ((state_q == S_IDLE) |
                               ((state_q == S_SHIFT) & (cnt_q == LAST)));
`endif
  assign accept = ser_if.load_valid & load_ready;

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dout_d       = 1'b0;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    do_load      = 1'b0;
`ifdef PISO_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      S_SHIFT: begin
        if (cnt_q != LAST) begin
          dout_d       = first_bit(sr_q);
          sr_d         = shift_word(sr_q);
          cnt_d        = cnt_q + 1'b1;
          dout_valid_d = 1'b1;
`ifdef PISO_PARITY_EN
          done_d       = 1'b0;
`else
          done_d       = (cnt_q == LAST - 1'b1);
`endif
        end else begin
`ifdef PISO_PARITY_EN
          state_d      = S_PARITY;
          dout_d       = par_q;
          dout_valid_d = 1'b1;
          done_d       = 1'b1;
          cnt_d        = CW'(WIDTH);
`else
          do_load      = accept;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: do_load = accept;
`endif
      default: do_load = accept;
    endcase

    // Frame end without a waiting word: drop back to idle. This only happens
    // in states where load_ready is high, i.e. at the final frame bit or idle.
    if (load_ready && !accept) begin
      state_d = S_IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end

    if (do_load) begin
      state_d      = S_SHIFT;
      cnt_d        = '0;
      dout_d       = first_bit(ser_if.data_in);
      sr_d         = shift_word(ser_if.data_in);
      dout_valid_d = 1'b1;
      done_d       = 1'b0;
`ifdef PISO_PARITY_EN
      par_d        = ^ser_if.data_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= (state_d != S_IDLE);
      done_q       <= done_d;
`ifdef PISO_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign ser_if.load_ready = load_ready;
  assign ser_if.dout       = dout_q;
  assign ser_if.dout_valid = dout_valid_q;
  assign ser_if.busy       = busy_q;
  assign ser_if.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized self-checking bench for piso_serializer
module tb_piso_serializer;
  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FW = W + PB;

  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) m_if ();
  piso_serializer_if #(.WIDTH(W)) l_if ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .ser_if(m_if.slave)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .ser_if(l_if.slave)
  );

  // Reference: a queue of bits still to appear on dout, front = current bit.
  ent_t qm[$];
  ent_t ql[$];
  int n_checks = 0;
  int n_errors = 0;
  logic acc_q;
  logic [FW-1:0] sipo_m, sipo_l;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    m_if.load_valid = v;
    l_if.load_valid = v;
    m_if.data_in    = d;
    l_if.data_in    = d;
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    ent_t e;
    for (int i = 0; i < W; i++) begin
      e.last = (i == W - 1) && (PB == 0);
      e.b = d[W-1-i];
      qm.push_back(e);
      e.b = d[i];
      ql.push_back(e);
    end
    if (PB != 0) begin
      e.last = 1'b1;
      e.b = ^d;
      qm.push_back(e);
      ql.push_back(e);
    end
  endtask

  task automatic check_outputs();
    ent_t fm, fl;
    fm = (qm.size() > 0) ? qm[0] : '0;
    fl = (ql.size() > 0) ? ql[0] : '0;
    check("m_valid", m_if.dout_valid, qm.size() > 0);
    check("m_dout",  m_if.dout, fm.b);
    check("m_done",  m_if.done, fm.last);
    check("m_busy",  m_if.busy, qm.size() > 0);
    check("m_ready", m_if.load_ready, qm.size() <= 1);
    check("l_valid", l_if.dout_valid, ql.size() > 0);
    check("l_dout",  l_if.dout, fl.b);
    check("l_done",  l_if.done, fl.last);
    check("l_busy",  l_if.busy, ql.size() > 0);
    check("l_ready", l_if.load_ready, ql.size() <= 1);
    if (m_if.dout_valid) sipo_m = {sipo_m[FW-2:0], m_if.dout};
    if (l_if.dout_valid) sipo_l = {sipo_l[FW-2:0], l_if.dout};
  endtask

  task automatic run_cycle(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    check_outputs();
    drive(v, d);
    @(posedge clk);
    acc_q = v && (qm.size() <= 1);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc_q) push_frame(d);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m"}, {m_if.dout, m_if.dout_valid, m_if.busy, m_if.done, m_if.load_ready}, 0);
    check({tag, "_l"}, {l_if.dout, l_if.dout_valid, l_if.busy, l_if.done, l_if.load_ready}, 0);
  endtask

  initial begin
    logic v;
    logic [W-1:0] d;
    logic pend;

    rst_n = 1'b0;
    drive(1'b0, '0);
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_ready_m", m_if.load_ready, 1);
    check("rel_ready_l", l_if.load_ready, 1);

    // Single word 1011 and its reassembly in a downstream shift register.
    sipo_m = '0;
    sipo_l = '0;
    run_cycle(1'b1, 4'b1011);
    repeat (FW + 1) run_cycle(1'b0, '0);
`ifdef PISO_PARITY_EN
    check("sipo_m", sipo_m, 5'b10111);
    check("sipo_l", sipo_l, 5'b11011);
`else
    check("sipo_m", sipo_m, 4'b1011);
    check("sipo_l", sipo_l, 4'b1101);
`endif

    // Back-to-back with load_valid held.
    run_cycle(1'b1, 4'b1011);
    repeat (FW) run_cycle(1'b1, 4'b0110);
    repeat (FW + 1) run_cycle(1'b0, '0);

    // Word offered mid-frame waits for the final bit.
    run_cycle(1'b1, 4'b1001);
    run_cycle(1'b0, '0);
    repeat (FW - 1) run_cycle(1'b1, 4'b1111);
    repeat (FW + 1) run_cycle(1'b0, '0);

    // Reset two bits into a frame of 1100, then a clean 0011.
    run_cycle(1'b1, 4'b1100);
    run_cycle(1'b0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    qm.delete();
    ql.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(1'b1, 4'b0011);
    repeat (FW + 1) run_cycle(1'b0, '0);

    // Random traffic; an unaccepted word is held stable until taken.
    pend = 1'b0;
    v = 1'b0;
    d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        v = ($urandom_range(0, 99) < 60);
        d = W'($urandom);
      end
      run_cycle(v, d);
      pend = v && !acc_q;
    end
    repeat (FW + 2) run_cycle(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
